// File: rtl/prng_mt19937.sv
// MT19937 32-bit Mersenne Twister: seeds a 624-word state, twists it in place, streams tempered words.
// Optional build macro PRNG_SEED_PORT_EN adds a run-time seed_in port used instead of SEED.
module prng_mt19937 #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [31:0] SEED       = 32'd5489
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  re_start,
`ifdef PRNG_SEED_PORT_EN
  input  logic [31:0]           seed_in,
`endif
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  end_random
);

  localparam int unsigned N     = 624;
  localparam int unsigned IDX_W = 10;

  localparam logic [IDX_W-1:0] LAST_IDX = 10'd623;
  localparam logic [IDX_W-1:0] FAR_OFF  = 10'd397;
  localparam logic [IDX_W-1:0] FAR_WRAP = 10'd227;
  localparam logic [31:0]      MATRIX_A = 32'h9908_B0DF;
  localparam logic [31:0]      UPPER    = 32'h8000_0000;
  localparam logic [31:0]      LOWER    = 32'h7FFF_FFFF;
  localparam logic [31:0]      INIT_MUL = 32'd1812433253;

  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("prng_mt19937: DATA_WIDTH must be 32");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_TWIST,
    S_OUT_RD,
    S_OUT_WR,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_end_random;

  logic [31:0]           r_mt [N];

  logic [IDX_W-1:0]      w_ra_cur;
  logic [IDX_W-1:0]      w_ra_nxt;
  logic [IDX_W-1:0]      w_ra_far;
  logic [31:0]           w_mt_cur;
  logic [31:0]           w_mt_nxt;
  logic [31:0]           w_mt_far;
  logic [31:0]           w_y;
  logic [31:0]           w_twist;
  logic [31:0]           w_init;
  logic [31:0]           w_seed;
  logic                  w_we;
  logic [IDX_W-1:0]      w_wa;
  logic [31:0]           w_wd;

  function automatic logic [31:0] temper(input logic [31:0] y_in);
    logic [31:0] y;
    y = y_in;
    y = y ^ (y >> 11);
    y = y ^ ((y << 7) & 32'h9D2C_5680);
    y = y ^ ((y << 15) & 32'hEFC6_0000);
    y = y ^ (y >> 18);
    return y;
  endfunction

`ifdef PRNG_SEED_PORT_EN
  assign w_seed = seed_in;
`else
  assign w_seed = SEED;
`endif

  // INIT reads the previous word; TWIST reads i, i+1 and i+397 (both modulo 624).
  assign w_ra_cur = (r_state == S_INIT) ? r_idx - 10'd1 : r_idx;
  assign w_ra_nxt = (r_idx == LAST_IDX) ? '0 : r_idx + 10'd1;
  assign w_ra_far = (r_idx >= FAR_WRAP) ? r_idx - FAR_WRAP : r_idx + FAR_OFF;

  assign w_mt_cur = r_mt[w_ra_cur];
  assign w_mt_nxt = r_mt[w_ra_nxt];
  assign w_mt_far = r_mt[w_ra_far];

  assign w_y      = (w_mt_cur & UPPER) | (w_mt_nxt & LOWER);
  assign w_twist  = w_mt_far ^ (w_y >> 1) ^ (w_y[0] ? MATRIX_A : 32'd0);
  assign w_init   = INIT_MUL * (w_mt_cur ^ (w_mt_cur >> 30)) + {{(32-IDX_W){1'b0}}, r_idx};

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and infers a latch.
  always_comb begin
    w_we = 1'b0;
    w_wa = r_idx;
    w_wd = w_twist;
    if (rst_n) begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            w_we = 1'b1;
            w_wa = '0;
            w_wd = w_seed;
          end
        end
        S_INIT: begin
          w_we = 1'b1;
          w_wd = w_init;
        end
        S_TWIST: begin
          w_we = 1'b1;
          w_wd = w_twist;
        end
        default: ;
      endcase
    end
  end

  // NOTE: the state array has no reset; it is fully rewritten by INIT before it is ever read, and a reset port would block RAM inference.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mt[w_wa] <= w_wd;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_out_valid  <= 1'b0;
      r_data_out   <= '0;
      r_end_random <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_idx   <= 10'd1;
            r_state <= S_INIT;
          end
        end
        S_INIT: begin
          if (r_idx == LAST_IDX) begin
            r_idx   <= '0;
            r_state <= S_TWIST;
          end else begin
            r_idx <= r_idx + 10'd1;
          end
        end
        S_TWIST: begin
          if (r_idx == LAST_IDX) begin
            r_idx   <= '0;
            r_state <= S_OUT_RD;
          end else begin
            r_idx <= r_idx + 10'd1;
          end
        end
        S_OUT_RD: begin
          if (re_start) begin
            r_idx   <= '0;
            r_state <= S_TWIST;
          end else begin
            // Output registers load here so the pulse is visible during the OUT_WR cycle.
            r_data_out  <= temper(w_mt_cur);
            r_out_valid <= 1'b1;
            r_state     <= S_OUT_WR;
          end
        end
        S_OUT_WR: begin
          r_out_valid <= 1'b0;
          if (re_start) begin
            r_idx   <= '0;
            r_state <= S_TWIST;
          end else if (r_idx == LAST_IDX) begin
            r_end_random <= 1'b1;
            r_state      <= S_DONE;
          end else begin
            r_idx   <= r_idx + 10'd1;
            r_state <= S_OUT_RD;
          end
        end
        S_DONE: begin
          if (start) begin
            r_end_random <= 1'b0;
            r_idx        <= 10'd1;
            r_state      <= S_INIT;
          end else if (re_start) begin
            r_end_random <= 1'b0;
            r_idx        <= '0;
            r_state      <= S_TWIST;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign out_valid  = r_out_valid;
  assign data_out   = r_data_out;
  assign end_random = r_end_random;

endmodule

// File: tb/tb_prng_mt19937.sv
// Scoreboard bench for prng_mt19937 against a software-style MT19937 model; supports PRNG_SEED_PORT_EN.
module tb_prng_mt19937;

  localparam logic [31:0] SEED = 32'd5489;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        re_start;
  logic        out_valid;
  logic [31:0] data_out;
  logic        end_random;
`ifdef PRNG_SEED_PORT_EN
  logic [31:0] seed_in;
`endif

  prng_mt19937 #(.DATA_WIDTH(32), .SEED(SEED)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .re_start  (re_start),
`ifdef PRNG_SEED_PORT_EN
    .seed_in   (seed_in),
`endif
    .out_valid (out_valid),
    .data_out  (data_out),
    .end_random(end_random)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          n_words = 0;
  int          batch_pos = 0;
  int          first_cyc = 0;
  int          last_cyc = 0;
  logic        prev_valid = 1'b0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  logic [31:0] m_mt [624];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h (%0d) expected 0x%08h (%0d)", name, act, act, req, req);
    end
  endtask

  // Reference model: textbook MT19937 on a plain array.
  function automatic void m_seed(input logic [31:0] s);
    m_mt[0] = s;
    for (int i = 1; i < 624; i++)
      m_mt[i] = 32'd1812433253 * (m_mt[i-1] ^ (m_mt[i-1] >> 30)) + 32'(i);
  endfunction

  function automatic void m_twist();
    logic [31:0] y;
    for (int i = 0; i < 624; i++) begin
      y = (m_mt[i] & 32'h8000_0000) | (m_mt[(i+1)%624] & 32'h7FFF_FFFF);
      m_mt[i] = m_mt[(i+397)%624] ^ (y >> 1) ^ (y[0] ? 32'h9908_B0DF : 32'd0);
    end
  endfunction

  function automatic logic [31:0] m_temper(input logic [31:0] x);
    logic [31:0] y;
    y = x;
    y ^= y >> 11;
    y ^= (y << 7) & 32'h9D2C_5680;
    y ^= (y << 15) & 32'hEFC6_0000;
    y ^= y >> 18;
    return y;
  endfunction

  function automatic void push_batch();
    m_twist();
    for (int k = 0; k < 624; k++) exp_q.push_back(m_temper(m_mt[k]));
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: pops the scoreboard whenever the DUT presents a word.
  initial forever begin
    logic [31:0] e;
    @(posedge clk);
    #1;
    if (rst_n && out_valid) begin
      check("pulse_width", {31'd0, prev_valid}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got 0x%08h expected no word", data_out);
      end else begin
        e = exp_q.pop_front();
        check("word", data_out, e);
      end
      if (batch_pos == 0) first_cyc = cyc;
      else check("spacing", 32'(cyc - last_cyc), 32'd2);
      last_cyc = cyc;
      batch_pos++;
      n_words++;
      got_q.push_back(data_out);
    end
    prev_valid = out_valid;
  end

  task automatic wait_words(input int target, input int budget, input string what);
    int b;
    b = budget;
    while (n_words < target && b > 0) begin
      @(negedge clk);
      b--;
    end
    if (n_words < target) check(what, 32'(n_words), 32'(target));
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    int s_cyc;
    int r_cyc;
    int base;
    int abort_at;
    start    = 1'b0;
    re_start = 1'b0;
    rst_n    = 1'b0;
`ifdef PRNG_SEED_PORT_EN
    seed_in  = SEED;
`endif
    repeat (3) @(negedge clk);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", data_out, 32'd0);
    check("rst_end", {31'd0, end_random}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Batch 1 with ignored start/re_start pulses during INIT, TWIST and OUTPUT.
    base = n_words; batch_pos = 0;
    m_seed(SEED); push_batch();
    s_cyc = cyc; start = 1'b1; @(negedge clk); start = 1'b0;
    wait_until(s_cyc + int'($urandom_range(10, 600)));
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_until(s_cyc + int'($urandom_range(650, 1200)));
    re_start = 1'b1; @(negedge clk); re_start = 1'b0;
    wait_words(base + 1, 1400, "first_word_timeout");
    check("start_latency", 32'(first_cyc - s_cyc), 32'd1249);
    wait_words(base + 5 + int'($urandom_range(0, 20)), 100, "mid_timeout");
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_words(base + 624, 1400, "batch1_timeout");
    check("end_before_rise", {31'd0, end_random}, 32'd0);
    @(negedge clk);
    check("end_rise", {31'd0, end_random}, 32'd1);
    check("seed5489_w0", got_q[0], 32'hD091_BB5C);
    check("seed5489_w1", got_q[1], 32'h22AE_9EF6);
    check("seed5489_w2", got_q[2], 32'hE7E1_FAEE);
    repeat (40) @(negedge clk);
    check("no_extra_words", 32'(n_words), 32'(base + 624));
    check("end_held", {31'd0, end_random}, 32'd1);

    // re_start in DONE continues the stream with words 625..1248.
    base = n_words; batch_pos = 0;
    push_batch();
    r_cyc = cyc; re_start = 1'b1; @(negedge clk); re_start = 1'b0;
    check("end_fall_restart", {31'd0, end_random}, 32'd0);
    wait_words(base + 1, 700, "restart_timeout");
    check("restart_latency", 32'(first_cyc - r_cyc), 32'd626);

    // Abort mid-batch at a random word; remaining words are discarded.
    abort_at = int'($urandom_range(50, 150));
    wait_words(base + abort_at, 400, "pre_abort_timeout");
    re_start = 1'b1; r_cyc = cyc;
    exp_q.delete(); batch_pos = 0; base = n_words;
    push_batch();
    @(negedge clk); re_start = 1'b0;
    wait_words(base + 1, 700, "abort_timeout");
    check("abort_latency", 32'(first_cyc - r_cyc), 32'd626);
    wait_words(base + 624, 1400, "abort_batch_timeout");
    @(negedge clk);
    check("end_after_abort_batch", {31'd0, end_random}, 32'd1);

    // start and re_start together in DONE: start wins and re-seeds.
    base = n_words; batch_pos = 0;
    m_seed(SEED); push_batch();
    s_cyc = cyc; start = 1'b1; re_start = 1'b1; @(negedge clk); start = 1'b0; re_start = 1'b0;
    check("end_fall_reseed", {31'd0, end_random}, 32'd0);
    wait_words(base + 3, 1400, "reseed_timeout");
    check("reseed_latency", 32'(first_cyc - s_cyc), 32'd1249);

    // Reset mid-output, then a fresh start reproduces the seed-5489 stream.
    rst_n = 1'b0; exp_q.delete();
    @(negedge clk);
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_data", data_out, 32'd0);
    check("midrst_end", {31'd0, end_random}, 32'd0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("idle_after_reset", 32'(n_words), 32'(base + 3));
    base = n_words; batch_pos = 0;
    m_seed(SEED); push_batch();
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_words(base + 1, 1400, "post_reset_timeout");
    check("post_reset_w0", got_q[got_q.size()-1], 32'hD091_BB5C);

`ifdef PRNG_SEED_PORT_EN
    rst_n = 1'b0; exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    base = n_words; batch_pos = 0;
    m_seed(32'd1); push_batch();
    seed_in = 32'd1; start = 1'b1; @(negedge clk); start = 1'b0;
    seed_in = $urandom;
    wait_words(base + 1, 1400, "seed_in_timeout");
    check("seed_in1_w0", got_q[got_q.size()-1], 32'h6AC1_F425);
`endif

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
